csr_file: RTL and testbench

//  Machine-mode CSR file for the RV32 core. Sits in EX, downstream of CSR_counter:
//  it consumes the 64-bit cycle/instret values and exposes them as 32-bit CSRs.
//  It executes CSRRW/RS/RC(I), holds mstatus/mie/mtvec/mepc and samples mip.
//  On interrupt entry or mret it produces a one-cycle redirect to the pipeline.

---
 rtl/csr_file.sv | 161 ++++++++++++++++
 tb/tb_csr_file.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: executes CSRRW/RS/RC(I), holds
// mstatus/mie/mtvec/mepc, exposes the upstream counters and redirects on interrupt or mret.
module csr_file #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        csr_en,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_src,
  input  logic [4:0]  csr_zimm,
  input  logic        csr_src_zero,
  input  logic        stall,
  input  logic        mret,
  input  logic [31:0] pc_ex,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  input  logic [63:0] cycle_cnt,
  input  logic [63:0] instret_cnt,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    K_NONE = 2'b00,
    K_RW   = 2'b01,
    K_RS   = 2'b10,
    K_RC   = 2'b11
  } kind_t;

  kind_t       kind;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_meie;
  logic        mie_mtie;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;

  logic [31:0] old_val;
  logic        mapped;
  logic        writable;
  logic [31:0] operand;
  logic [31:0] wdata;
  logic        write_req;
  logic        illegal_raw;
  logic        pend;
  logic        take_irq;
  logic        take_mret;
  logic        do_write;

  assign kind    = kind_t'(csr_op[1:0]);
  assign operand = csr_op[2] ? {27'b0, csr_zimm} : csr_src;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it latched.
  always_comb begin
    old_val  = 32'b0;
    mapped   = 1'b1;
    writable = 1'b0;
    case (csr_addr)
      12'hC00, 12'hB00: old_val = cycle_cnt[31:0];
      12'hC80, 12'hB80: old_val = cycle_cnt[63:32];
      12'hC02, 12'hB02: old_val = instret_cnt[31:0];
      12'hC82, 12'hB82: old_val = instret_cnt[63:32];
      12'h300: begin
        old_val  = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
        writable = 1'b1;
      end
      12'h304: begin
        old_val  = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
        writable = 1'b1;
      end
      12'h305: begin
        old_val  = mtvec_q;
        writable = 1'b1;
      end
      12'h341: begin
        old_val  = mepc_q;
        writable = 1'b1;
      end
      12'h344: old_val = {20'b0, ext_irq, 3'b0, tmr_irq, 7'b0};
      12'hF14: old_val = HART_ID;
      default: mapped = 1'b0;
    endcase
  end

  // Set/clear forms only count as writes when their source is non-zero.
  always_comb begin
    wdata     = old_val;
    write_req = 1'b0;
    case (kind)
      K_RW: begin
        wdata     = operand;
        write_req = 1'b1;
      end
      K_RS: begin
        wdata     = old_val | operand;
        write_req = csr_op[2] ? (csr_zimm != 5'd0) : !csr_src_zero;
      end
      K_RC: begin
        wdata     = old_val & ~operand;
        write_req = csr_op[2] ? (csr_zimm != 5'd0) : !csr_src_zero;
      end
      default: ;
    endcase
  end

  assign illegal_raw = csr_en && (!mapped || (write_req && !writable));
  assign csr_illegal = illegal_raw && !RST;
  assign csr_rdata   = illegal_raw ? 32'b0 : old_val;

  assign pend      = mstatus_mie && ((mie_meie && ext_irq) || (mie_mtie && tmr_irq));
  assign take_irq  = pend && !stall;
  assign take_mret = mret && !pend && !stall;
  assign redirect  = (take_irq || take_mret) && !RST;

  always_comb begin
    redirect_pc = 32'b0;
    if (redirect) redirect_pc = take_irq ? mtvec_q : mepc_q;
  end

  // An interrupt replays the EX instruction later, so its write must not land now.
  assign do_write = csr_en && write_req && !illegal_raw && !stall && !pend && !mret;

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec_q      <= MTVEC_RST & 32'hFFFF_FFFC;
      mepc_q       <= 32'b0;
    end else if (take_irq) begin
      mepc_q       <= pc_ex & 32'hFFFF_FFFC;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (take_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        12'h300: begin
          mstatus_mie  <= wdata[3];
          mstatus_mpie <= wdata[7];
        end
        12'h304: begin
          mie_meie <= wdata[11];
          mie_mtie <= wdata[7];
        end
        12'h305: mtvec_q <= wdata & 32'hFFFF_FFFC;
        12'h341: mepc_q  <= wdata & 32'hFFFF_FFFC;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus a randomized run
// against a word-level reference model of the CSR map.
module tb_csr_file;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0107;
  localparam logic [31:0] HART_ID   = 32'h0000_0003;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        csr_en = 1'b0;
  logic [2:0]  csr_op = 3'b000;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_src = 32'b0;
  logic [4:0]  csr_zimm = 5'b0;
  logic        csr_src_zero = 1'b0;
  logic        stall = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] pc_ex = 32'b0;
  logic        ext_irq = 1'b0;
  logic        tmr_irq = 1'b0;
  logic [63:0] cycle_cnt = 64'b0;
  logic [63:0] instret_cnt = 64'b0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        redirect;
  logic [31:0] redirect_pc;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state, kept as whole CSR words.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc;

  csr_file #(.MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
    .CLK(CLK), .RST(RST), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_src(csr_src), .csr_zimm(csr_zimm), .csr_src_zero(csr_src_zero), .stall(stall),
    .mret(mret), .pc_ex(pc_ex), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] src, input logic [4:0] zimm, input logic sz);
    csr_en = en; csr_op = op; csr_addr = addr; csr_src = src; csr_zimm = zimm; csr_src_zero = sz;
  endtask

  // A read is an RS with rs1 = x0: legal on every mapped address.
  task automatic read_at(input logic [11:0] addr);
    drive(1'b1, 3'b010, addr, 32'b0, 5'b0, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 12'h000, 32'b0, 5'b0, 1'b0);
    mret = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; idle(); mret = 1'b1;
    #2;
    tests_run++;
    if (redirect !== 1'b0 || redirect_pc !== 32'b0 || csr_illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got redirect=%b pc=%h illegal=%b required 0/0/0", redirect, redirect_pc, csr_illegal);
    end
    mret = 1'b0;
    @(negedge CLK); RST = 1'b0;
    tick();
    read_at(12'h300); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h0000_1800) begin tests_failed++; $display("FAIL reset_mstatus: got %h required %h", csr_rdata, 32'h1800); end
    read_at(12'h304); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_mie: got %h required 0", csr_rdata); end
    read_at(12'h305); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h0000_0104 || csr_illegal !== 1'b0 || redirect !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mtvec: got %h illegal=%b redirect=%b required 00000104/0/0", csr_rdata, csr_illegal, redirect);
    end
    tick(); idle();
  endtask

  task automatic test_counters();
    cycle_cnt = 64'h1_0000_0005; instret_cnt = 64'hABCD_0123_4567_89EF;
    read_at(12'hC00); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'd5) begin tests_failed++; $display("FAIL cycle_lo: got %h required 5", csr_rdata); end
    tick(); read_at(12'hC80); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'd1) begin tests_failed++; $display("FAIL cycle_hi: got %h required 1", csr_rdata); end
    tick(); read_at(12'hB82); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'hABCD_0123) begin tests_failed++; $display("FAIL minstret_hi: got %h required abcd0123", csr_rdata); end
    tick(); drive(1'b1, 3'b001, 12'hC00, 32'h1234, 5'b0, 1'b0); @(negedge CLK);
    tests_run++;
    if (csr_illegal !== 1'b1 || csr_rdata !== 32'b0) begin
      tests_failed++; $display("FAIL cycle_write_illegal: got illegal=%b rdata=%h required 1/0", csr_illegal, csr_rdata);
    end
    tick(); read_at(12'hC00); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'd5 || csr_illegal !== 1'b0) begin
      tests_failed++; $display("FAIL cycle_after_write: got %h illegal=%b required 5/0", csr_rdata, csr_illegal);
    end
    tick(); idle();
  endtask

  task automatic test_mstatus_ops();
    drive(1'b1, 3'b101, 12'h300, 32'b0, 5'd8, 1'b0); tick();
    drive(1'b1, 3'b111, 12'h300, 32'b0, 5'd0, 1'b0); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h0000_1808) begin tests_failed++; $display("FAIL rwi_mie: got %h required 1808", csr_rdata); end
    tick(); drive(1'b1, 3'b011, 12'h300, 32'h8, 5'd0, 1'b1); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h0000_1808) begin tests_failed++; $display("FAIL rci_zero_nowrite: got %h required 1808", csr_rdata); end
    tick(); drive(1'b1, 3'b010, 12'h300, 32'h80, 5'd0, 1'b1); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h0000_1808) begin tests_failed++; $display("FAIL rc_srczero_nowrite: got %h required 1808", csr_rdata); end
    tick(); read_at(12'h300); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h0000_1808) begin tests_failed++; $display("FAIL rs_srczero_nowrite: got %h required 1808", csr_rdata); end
    tick(); idle();
  endtask

  task automatic test_irq_and_mret();
    drive(1'b1, 3'b001, 12'h304, 32'h0000_0800, 5'd0, 1'b0); tick();
    drive(1'b1, 3'b001, 12'h305, 32'h0000_0200, 5'd0, 1'b0); tick();
    idle(); pc_ex = 32'h100; ext_irq = 1'b1; @(negedge CLK);
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin
      tests_failed++; $display("FAIL irq_redirect: got %b/%h required 1/00000200", redirect, redirect_pc);
    end
    tick(); ext_irq = 1'b0;
    read_at(12'h341); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h100) begin tests_failed++; $display("FAIL irq_mepc: got %h required 100", csr_rdata); end
    read_at(12'h300); #1;
    tests_run++;
    if (csr_rdata !== 32'h0000_1880) begin tests_failed++; $display("FAIL irq_mstatus: got %h required 1880", csr_rdata); end
    tick(); idle(); mret = 1'b1; @(negedge CLK);
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin
      tests_failed++; $display("FAIL mret_redirect: got %b/%h required 1/00000100", redirect, redirect_pc);
    end
    tick(); mret = 1'b0; read_at(12'h300); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h0000_1888) begin tests_failed++; $display("FAIL mret_mstatus: got %h required 1888", csr_rdata); end
    tick(); idle();
    // Interrupt and a CSR write in the same cycle: the write is dropped.
    drive(1'b1, 3'b001, 12'h305, 32'h0000_0400, 5'd0, 1'b0); ext_irq = 1'b1; pc_ex = 32'h100; @(negedge CLK);
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin
      tests_failed++; $display("FAIL irq_vs_write_redirect: got %b/%h required 1/00000200", redirect, redirect_pc);
    end
    tick(); ext_irq = 1'b0; read_at(12'h305); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h200) begin tests_failed++; $display("FAIL irq_vs_write_mtvec: got %h required 200", csr_rdata); end
    tick(); idle(); mret = 1'b1; tick(); mret = 1'b0;
  endtask

  task automatic test_stall();
    ext_irq = 1'b1; stall = 1'b1; pc_ex = 32'h444; mret = 1'b1;
    drive(1'b1, 3'b001, 12'h305, 32'h0000_0400, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      tests_run++;
      if (redirect !== 1'b0 || redirect_pc !== 32'b0) begin
        tests_failed++; $display("FAIL stall_redirect[%0d]: got %b/%h required 0/0", i, redirect, redirect_pc);
      end
      tick();
    end
    ext_irq = 1'b0; stall = 1'b0; mret = 1'b0;
    read_at(12'h305); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h200) begin tests_failed++; $display("FAIL stall_mtvec: got %h required 200", csr_rdata); end
    read_at(12'h300); #1;
    tests_run++;
    if (csr_rdata !== 32'h0000_1888) begin tests_failed++; $display("FAIL stall_mstatus: got %h required 1888", csr_rdata); end
    read_at(12'h341); #1;
    tests_run++;
    if (csr_rdata !== 32'h100) begin tests_failed++; $display("FAIL stall_mepc: got %h required 100", csr_rdata); end
    tick(); idle();
  endtask

  task automatic test_unmapped_and_mip();
    read_at(12'h7C0); @(negedge CLK);
    tests_run++;
    if (csr_illegal !== 1'b1 || csr_rdata !== 32'b0) begin
      tests_failed++; $display("FAIL unmapped_read: got illegal=%b rdata=%h required 1/0", csr_illegal, csr_rdata);
    end
    tick(); stall = 1'b1; ext_irq = 1'b1; tmr_irq = 1'b1; read_at(12'h344); @(negedge CLK);
    tests_run++;
    if (csr_rdata !== 32'h880 || csr_illegal !== 1'b0) begin
      tests_failed++; $display("FAIL mip_read: got %h illegal=%b required 880/0", csr_rdata, csr_illegal);
    end
    drive(1'b1, 3'b101, 12'h344, 32'b0, 5'd1, 1'b0); #1;
    tests_run++;
    if (csr_illegal !== 1'b1) begin tests_failed++; $display("FAIL mip_write_illegal: got %b required 1", csr_illegal); end
    tick(); ext_irq = 1'b0; tmr_irq = 1'b0; stall = 1'b0; idle();
  endtask

  task automatic test_async_reset();
    mret = 1'b1; @(negedge CLK);
    #2 RST = 1'b1; read_at(12'h300); #1;
    tests_run++;
    if (redirect !== 1'b0 || csr_rdata !== 32'h0000_1800) begin
      tests_failed++; $display("FAIL async_reset: got redirect=%b mstatus=%h required 0/1800", redirect, csr_rdata);
    end
    idle(); @(negedge CLK); RST = 1'b0; tick();
  endtask

  function automatic logic [32:0] ref_read(input logic [11:0] a);
    case (a)
      12'hC00, 12'hB00: return {1'b1, cycle_cnt[31:0]};
      12'hC80, 12'hB80: return {1'b1, cycle_cnt[63:32]};
      12'hC02, 12'hB02: return {1'b1, instret_cnt[31:0]};
      12'hC82, 12'hB82: return {1'b1, instret_cnt[63:32]};
      12'h300: return {1'b1, m_mstatus};
      12'h304: return {1'b1, m_mie};
      12'h305: return {1'b1, m_mtvec};
      12'h341: return {1'b1, m_mepc};
      12'h344: return {1'b1, 20'b0, ext_irq, 3'b0, tmr_irq, 7'b0};
      12'hF14: return {1'b1, HART_ID};
      default: return 33'b0;
    endcase
  endfunction

  task automatic test_random();
    logic [11:0] addrs [18];
    logic [2:0]  ops [6];
    logic [32:0] rd;
    logic [31:0] old, opnd, wd, exp_rd, exp_pc;
    logic        effect, ill, pend, exp_redir, writable;
    addrs = '{12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h300,
              12'h304, 12'h305, 12'h341, 12'h344, 12'hF14, 12'h300, 12'h304, 12'h7C0, 12'h301};
    ops = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    idle(); RST = 1'b1; #3 RST = 1'b0;
    m_mstatus = 32'h1800; m_mie = 32'h0; m_mtvec = MTVEC_RST & ~32'h3; m_mepc = 32'h0;
    tick();
    for (int n = 0; n < 600; n++) begin
      csr_en = ($urandom_range(1, 0) == 1);
      csr_op = ops[$urandom_range(5, 0)];
      csr_addr = addrs[$urandom_range(17, 0)];
      csr_src = ($urandom_range(3, 0) == 0) ? 32'h0 : $urandom;
      csr_zimm = 5'($urandom_range(31, 0) & ($urandom_range(1, 0) == 1 ? 31 : 8));
      csr_src_zero = ($urandom_range(3, 0) == 0);
      stall = ($urandom_range(3, 0) == 0);
      mret = ($urandom_range(7, 0) == 0);
      ext_irq = ($urandom_range(3, 0) == 0);
      tmr_irq = ($urandom_range(3, 0) == 0);
      pc_ex = $urandom;
      cycle_cnt = {$urandom, $urandom};
      instret_cnt = {$urandom, $urandom};
      @(negedge CLK);
      rd = ref_read(csr_addr);
      old = rd[31:0];
      writable = csr_addr inside {12'h300, 12'h304, 12'h305, 12'h341};
      opnd = csr_op[2] ? 32'(csr_zimm) : csr_src;
      effect = (csr_op[1:0] == 2'b01) || (csr_op[2] ? (csr_zimm != 0) : !csr_src_zero);
      ill = csr_en && (!rd[32] || (effect && !writable));
      exp_rd = ill ? 32'h0 : old;
      pend = m_mstatus[3] && ((m_mie[11] && ext_irq) || (m_mie[7] && tmr_irq));
      exp_redir = !stall && (pend || mret);
      exp_pc = !exp_redir ? 32'h0 : (pend ? m_mtvec : m_mepc);
      tests_run++;
      if (csr_rdata !== exp_rd || csr_illegal !== ill || redirect !== exp_redir || redirect_pc !== exp_pc) begin
        tests_failed++;
        $display("FAIL random[%0d] addr=%h op=%b: got rdata=%h ill=%b redir=%b pc=%h required %h/%b/%b/%h",
                 n, csr_addr, csr_op, csr_rdata, csr_illegal, redirect, redirect_pc, exp_rd, ill, exp_redir, exp_pc);
      end
      if (!stall) begin
        if (pend) begin
          m_mepc = pc_ex & ~32'h3;
          m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        end else if (mret) begin
          m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (csr_en && effect && !ill) begin
          case (csr_op[1:0])
            2'b01:   wd = opnd;
            2'b10:   wd = old | opnd;
            default: wd = old & ~opnd;
          endcase
          case (csr_addr)
            12'h300: m_mstatus = 32'h1800 | (wd & 32'h88);
            12'h304: m_mie = wd & 32'h880;
            12'h305: m_mtvec = wd & ~32'h3;
            default: m_mepc = wd & ~32'h3;
          endcase
        end
      end
      tick();
    end
    idle(); stall = 1'b0; ext_irq = 1'b0; tmr_irq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_counters();
    test_mstatus_ops();
    test_irq_and_mret();
    test_stall();
    test_unmapped_and_mip();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
